// File: rtl/debounce_edge_pkg.sv
// debounce_edge_pkg: shared FSM encodings and constant helpers for the debouncer
package debounce_edge_pkg;
  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/debounce_edge_sync_ff.sv
// sync_ff: shift-register synchronizer with synchronous reset to 0
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  // shift the raw input through the chain; reset empties it
  always_ff @(posedge clk)
    r <= reset ? '0 : {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: debounced level with rise/fall strobes and a wrapping rise counter
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic             out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_count
);
  localparam int CW = clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic s, last, rise_n, fall_n;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (s)
  );
  assign last = cnt == LAST;
  // state, qualification counter and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOW;
      cnt        <= '0;
      out        <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      rise_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      out        <= rise_n | (out & ~fall_n);
      rise       <= rise_n;
      fall       <= fall_n;
      rise_count <= rise_count + CNT_W'(rise_n);
    end
  end
  // any opposing sample drops back and restarts qualification from zero
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      LOW:     if (s) begin state_n = WAIT_HI; cnt_n = CW'(1); end
      WAIT_HI: if (!s) state_n = LOW; else if (last) state_n = HIGH; else cnt_n = cnt + 1'b1;
      HIGH:    if (!s) begin state_n = WAIT_LO; cnt_n = CW'(1); end
      WAIT_LO: if (s) state_n = HIGH; else if (last) state_n = LOW; else cnt_n = cnt + 1'b1;
    endcase
  end
  // a strobe fires only on the sample that completes a qualification run
  always_comb begin
    rise_n = state == WAIT_HI && s && last;
    fall_n = state == WAIT_LO && !s && last;
  end
endmodule
